// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Single-issue integer ALU execution unit with a valid/ready
//               request side and a valid/ready result side. Results and the
//               zero flag are registered. Non-shift operations (and shifts by
//               zero) complete with latency 1 and can stream back-to-back at
//               one operation per cycle.
//
//               Build option ALU_FAST_SHIFT_EN:
//                 defined   - shifts use a one-cycle barrel shifter.
//                 undefined - a shift by k > 0 walks one bit per cycle in the
//                             SHIFT state; out_valid rises k+1 cycles after
//                             the request is accepted.
//               Both builds produce identical results.
//
// Ports       :
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     request valid
//   in_ready   out  1     unit can accept a request this cycle
//   alu_ctrl   in   4     opcode (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU,
//                         codes 1010-1111 act as ADD)
//   src_a      in   XLEN  first operand
//   src_b      in   XLEN  second operand, shift amount is src_b[4:0]
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  registered result
//   zero       out  1     registered flag, result == 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   // ---------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // ---------------------------------------------------------------------
   // Opcodes
   // ---------------------------------------------------------------------
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   // ---------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------
   logic [1:0]      state_q,  state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q,   zero_d;

   logic            accept;        // request handshake completes this edge
   logic [4:0]      shamt;         // shift amount taken from src_b
   logic            start_serial;  // accepted request needs the SHIFT state
   logic [XLEN-1:0] alu_res;       // single-cycle result of the request inputs

`ifndef ALU_FAST_SHIFT_EN
   logic [XLEN-1:0] sh_q, sh_d;    // working value of the serial shifter
   logic [XLEN-1:0] sh_next;       // working value after one more bit step
   logic [4:0]      cnt_q, cnt_d;  // bit steps still to perform
   logic [1:0]      kind_q, kind_d;// low opcode bits: 01 SLL, 10 SRL, 11 SRA
   logic            is_shift;
`endif

   // ---------------------------------------------------------------------
   // Handshake and outputs
   // ---------------------------------------------------------------------
   // DONE can only take a new request when its current result is leaving
   // this cycle, which is what allows one operation per cycle.
   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

   assign shamt     = src_b[4:0];

   // ---------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------
   always_comb begin
      alu_res = src_a + src_b;
      case (alu_ctrl)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_XOR:  alu_res = src_a ^ src_b;
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL:  alu_res = src_a << shamt;
         OP_SRL:  alu_res = src_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
`else
         // Only a zero-amount shift finishes here; anything else is handed
         // to the serial shifter and this value is not used.
         OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
`endif
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         default: alu_res = src_a + src_b;   // unused codes behave as ADD
      endcase
   end

`ifndef ALU_FAST_SHIFT_EN
   // ---------------------------------------------------------------------
   // Serial shifter: one bit position per cycle while in SHIFT
   // ---------------------------------------------------------------------
   assign is_shift     = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                         (alu_ctrl == OP_SRA);
   assign start_serial = is_shift && (shamt != 5'd0);

   always_comb begin
      case (kind_q)
         2'b01:   sh_next = {sh_q[XLEN-2:0], 1'b0};
         2'b10:   sh_next = {1'b0, sh_q[XLEN-1:1]};
         default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      kind_d = kind_q;
      if (accept && start_serial) begin
         sh_d   = src_a;
         cnt_d  = shamt;
         kind_d = alu_ctrl[1:0];
      end else if (state_q == S_SHIFT) begin
         sh_d  = sh_next;
         cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         cnt_q  <= 5'd0;
         kind_q <= 2'b00;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         kind_q <= kind_d;
      end
   end
`else
   assign start_serial = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Control FSM and result register
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (start_serial) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d  = S_DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
               end
            end else if (state_q == S_DONE && out_ready) begin
               state_d = S_IDLE;
            end
            // DONE with !out_ready holds result and zero unchanged.
         end
         S_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
            // The last bit step lands straight in the result register so
            // out_valid rises exactly k+1 cycles after acceptance.
            if (cnt_q == 5'd1) begin
               state_d  = S_DONE;
               result_d = sh_next;
               zero_d   = (sh_next == '0);
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit. Inputs are
//               driven 1 time unit after the rising edge and outputs are
//               sampled at the same point, so every sample reflects the
//               edge just taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   localparam int XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0]      alu_ctrl = 4'd0;
   logic [XLEN-1:0] src_a = '0;
   logic [XLEN-1:0] src_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            zero;

   int n_cmp = 0;
   int n_err = 0;

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      alu_ctrl = op;
      src_a    = a;
      src_b    = b;
   endtask

   // Issues one request from IDLE with out_ready=1 and waits (bounded) for
   // the result; lat counts edges from acceptance (1 = next cycle).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic zf);
      drive(op, a, b);
      tick;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick;
         lat++;
      end
      res = result;
      zf  = zero;
      tick;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      tick;
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", result); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
      rst_n = 1'b1;
      tick;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add_overflow;
      out_ready = 1'b1;
      drive(4'b0000, 32'h7FFF_FFFF, 32'h1);
      tick;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h want 80000000", result); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero: got %b want 0", zero); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_sub_hold;
      out_ready = 1'b0;
      drive(4'b0001, 32'd5, 32'd5);
      tick;
      // A new request while stalled must be ignored.
      drive(4'b0000, 32'd1, 32'd2);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick;
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
         n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL hold_result[%0d]: got %h want 00000000", i, result); end
         n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL hold_zero[%0d]: got %b want 1", i, zero); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", out_valid); end
   endtask

   task automatic test_sra_long;
      int lat;
      out_ready = 1'b1;
      drive(4'b0111, 32'h8000_0000, 32'd31);
      tick;
      in_valid = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sra_busy_in_ready: got %b want 0", in_ready); end
`endif
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick;
         lat++;
      end
      n_cmp++; if (lat != (FAST ? 1 : 32)) begin n_err++; $display("FAIL sra_latency: got %0d want %0d", lat, (FAST ? 1 : 32)); end
      n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sra_result: got %h want ffffffff", result); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL sra_zero: got %b want 0", zero); end
      tick;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      drive(4'b1000, 32'hFFFF_FFFF, 32'd1);
      tick;
      drive(4'b1001, 32'hFFFF_FFFF, 32'd1);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_slt_valid: got %b want 1", out_valid); end
      n_cmp++; if (result !== 32'd1) begin n_err++; $display("FAIL b2b_slt_result: got %h want 00000001", result); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_sltu_valid: got %b want 1", out_valid); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL b2b_sltu_result: got %h want 00000000", result); end
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL b2b_sltu_zero: got %b want 1", zero); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_alu_table;
      logic [3:0]  t_op  [15] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                 4'b1000, 4'b1000, 4'b1001, 4'b1100, 4'b1111,
                                 4'b0101, 4'b0110, 4'b0111, 4'b0110, 4'b0110};
      logic [31:0] t_a   [15] = '{32'd1, 32'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'd5, 32'h80000000, 32'd1, 32'd3, 32'hFFFFFFFF,
                                 32'd1, 32'h80000000, 32'h80000010, 32'h00001234, 32'h80000000};
      logic [31:0] t_b   [15] = '{32'd2, 32'd1, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd1,
                                 32'd10, 32'd4, 32'd4, 32'd32, 32'd1};
      logic [31:0] t_exp [15] = '{32'd3, 32'hFFFFFFFF, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00,
                                 32'd0, 32'd1, 32'd1, 32'd7, 32'd0,
                                 32'h00000400, 32'h08000000, 32'hF8000001, 32'h00001234, 32'h40000000};
      int          t_lat [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 11, 5, 5, 1, 2};
      int          lat;
      logic [31:0] res;
      logic        zf;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], lat, res, zf);
         n_cmp++; if (res !== t_exp[i]) begin n_err++; $display("FAIL op[%0d]_result: got %h want %h", i, res, t_exp[i]); end
         n_cmp++; if (zf !== (t_exp[i] == 32'd0)) begin n_err++; $display("FAIL op[%0d]_zero: got %b want %b", i, zf, (t_exp[i] == 32'd0)); end
         n_cmp++; if (lat != (FAST ? 1 : t_lat[i])) begin n_err++; $display("FAIL op[%0d]_latency: got %0d want %0d", i, lat, (FAST ? 1 : t_lat[i])); end
      end
   endtask

   task automatic test_reset_mid_shift;
      int          lat;
      logic [31:0] res;
      logic        zf;
      out_ready = 1'b1;
      drive(4'b0101, 32'd1, 32'd10);
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      tick;
`ifndef ALU_FAST_SHIFT_EN
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midshift_busy: got %b want 0", in_ready); end
`endif
      rst_n = 1'b0;
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midshift_async_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midshift_async_result: got %h want 00000000", result); end
      tick;
      rst_n = 1'b1;
      tick;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midshift_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midshift_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midshift_result: got %h want 00000000", result); end
      // A fresh shift after reset must start from a cleared counter.
      run_op(4'b0101, 32'd1, 32'd10, lat, res, zf);
      n_cmp++; if (res !== 32'h400) begin n_err++; $display("FAIL post_reset_sll_result: got %h want 00000400", res); end
      n_cmp++; if (lat != (FAST ? 1 : 11)) begin n_err++; $display("FAIL post_reset_sll_latency: got %0d want %0d", lat, (FAST ? 1 : 11)); end
   endtask

   initial begin
      test_reset;
      test_add_overflow;
      test_sub_hold;
      test_sra_long;
      test_back_to_back;
      test_alu_table;
      test_reset_mid_shift;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
